score_bcd_converter: RTL and testbench



---
 rtl/game_pkg.sv | 24 ++
 rtl/score_bcd_converter_dd_step.sv | 28 ++
 rtl/score_bcd_converter.sv | 147 ++++++++++++++
 tb/tb_score_bcd_converter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants, converter state encoding
// and the decimal saturation helper.
package game_pkg;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_SHIFT = 2'd1,
    SC_DONE  = 2'd2
  } sc_state_e;

  localparam int SCORE_W      = 32;
  localparam int SCORE_DIGITS = 8;

  // Largest value representable in n decimal digits.
  function automatic logic [63:0] pow10m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/score_bcd_converter_dd_step.sv
// One double-dabble iteration: add-3 on every
// nibble >= 5, then shift the whole vector left.
module dd_step
  import game_pkg::*;
#(
  parameter int DIGITS = SCORE_DIGITS,
  parameter int BIN_W  = SCORE_W
) (
  input  logic [DIGITS*4+BIN_W-1:0] v_i,
  output logic [DIGITS*4+BIN_W-1:0] v_o
);

  localparam int W = DIGITS * 4 + BIN_W;

  logic [W-1:0] adj;

  // Adjust each BCD nibble, then shift by one bit.
  always_comb begin
    adj = v_i;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[BIN_W+4*d +: 4] >= 4'd5) begin
        adj[BIN_W+4*d +: 4] = adj[BIN_W+4*d +: 4] + 4'd3;
      end
    end
    v_o = {adj[W-2:0], 1'b0};
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD score converter with
// leading-zero blanking and decimal saturation.
module score_bcd_converter
  import game_pkg::*;
#(
  parameter int BIN_W  = SCORE_W,
  parameter int DIGITS = SCORE_DIGITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BIN_W-1:0]      BINARY_SCORE,
  input  logic                  FORCE_START,
  output logic [DIGITS*4-1:0]   BCD_OUT,
  output logic [DIGITS-1:0]     BLANK,
  output logic                  VALID,
  output logic                  BUSY,
  output logic                  OVERFLOW
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);
  localparam logic [63:0] MAX64 = pow10m1(DIGITS);
  // No saturation needed when every binary value fits.
  localparam bit SAT_EN =
    (BIN_W < 64) && (MAX64 < (64'd1 << BIN_W));
  localparam logic [BIN_W-1:0] MAX_BIN = MAX64[BIN_W-1:0];
  localparam logic [DIGITS-1:0] BLANK_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  sc_state_e         state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  last_q, last_d;
  logic              ovfp_q, ovfp_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              start, over;
  logic              zrun;

  dd_step #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) u_step (
    .v_i(sr_q),
    .v_o(sr_step)
  );

  assign start = (BINARY_SCORE != last_q) || FORCE_START;
  assign over  = SAT_EN && (64'(BINARY_SCORE) > MAX64);

  // Leading-zero mask: digit i dark iff i..top are zero.
  always_comb begin
    blank_calc = '0;
    zrun       = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun          = zrun && (sr_q[BIN_W+4*i +: 4] == 4'd0);
      blank_calc[i] = zrun;
    end
  end

  // Next-state and datapath update for the converter FSM.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ovfp_d  = ovfp_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    unique case (state_q)
      SC_IDLE: begin
        if (start) begin
          last_d = BINARY_SCORE;
          if (over) begin
            sr_d   = {{BCD_W{1'b0}}, MAX_BIN};
            ovfp_d = 1'b1;
          end else begin
            sr_d   = {{BCD_W{1'b0}}, BINARY_SCORE};
            ovfp_d = 1'b0;
          end
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = SC_SHIFT;
        end
      end
      SC_SHIFT: begin
        sr_d = sr_step;
        if (cnt_q == '0) begin
          state_d = SC_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SC_DONE: begin
        bcd_d   = sr_q[SR_W-1:BIN_W];
        ovf_d   = ovfp_q;
        blank_d = blank_calc;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = SC_IDLE;
      end
      default: state_d = SC_IDLE;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SC_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      ovfp_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ovfp_q  <= ovfp_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign BCD_OUT  = bcd_q;
  assign BLANK    = blank_q;
  assign VALID    = valid_q;
  assign BUSY     = busy_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed table-driven bench for the score
// binary-to-BCD converter.
module tb_score_bcd_converter;

  logic        CLK;
  logic        RST;
  logic [31:0] BINARY_SCORE;
  logic        FORCE_START;
  logic [31:0] BCD_OUT;
  logic [7:0]  BLANK;
  logic        VALID;
  logic        BUSY;
  logic        OVERFLOW;

  int checks;
  int errors;
  int vcnt;

  score_bcd_converter dut (
    .CLK         (CLK),
    .RST         (RST),
    .BINARY_SCORE(BINARY_SCORE),
    .FORCE_START (FORCE_START),
    .BCD_OUT     (BCD_OUT),
    .BLANK       (BLANK),
    .VALID       (VALID),
    .BUSY        (BUSY),
    .OVERFLOW    (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (VALID) vcnt = vcnt + 1;
  end

  typedef struct {
    logic [31:0] score;
    logic [31:0] bcd;
    logic [7:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // Negedges until VALID (first is just after edge k).
  task automatic wait_valid(output int lat,
                            output int bcyc);
    lat  = 0;
    bcyc = 0;
    for (int n = 1; n <= 120; n++) begin
      @(negedge CLK);
      if (BUSY) bcyc = bcyc + 1;
      if (VALID) begin
        lat = n;
        return;
      end
    end
    lat = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  int lat, bcyc, v0;
  int seen_busy;

  initial begin
    checks       = 0;
    errors       = 0;
    vcnt         = 0;
    RST          = 1'b1;
    BINARY_SCORE = 32'd0;
    FORCE_START  = 1'b0;

    vecs[0] = '{32'd1234,       32'h00001234, 8'hF0, 1'b0};
    vecs[1] = '{32'd99999999,   32'h99999999, 8'h00, 1'b0};
    vecs[2] = '{32'd100000000,  32'h99999999, 8'h00, 1'b1};
    vecs[3] = '{32'd0,          32'h00000000, 8'hFE, 1'b0};
    vecs[4] = '{32'd5,          32'h00000005, 8'hFE, 1'b0};
    vecs[5] = '{32'd10,         32'h00000010, 8'hFC, 1'b0};
    vecs[6] = '{32'hFFFFFFFF,   32'h99999999, 8'h00, 1'b1};
    vecs[7] = '{32'd10000000,   32'h10000000, 8'h00, 1'b0};
    vecs[8] = '{32'd65535,      32'h00065535, 8'hE0, 1'b0};

    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Idle with score 0: nothing converts.
    seen_busy = 0;
    v0 = vcnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (BUSY) seen_busy = 1;
    end
    chk("idle_bcd", 64'(BCD_OUT), 64'h0);
    chk("idle_blank", 64'(BLANK), 64'hFE);
    chk("idle_ovf", 64'(OVERFLOW), 64'h0);
    chk("idle_busy", 64'(seen_busy), 64'h0);
    chk("idle_valid", 64'(vcnt - v0), 64'h0);

    // Table: latency, busy length, result, pulse width.
    foreach (vecs[i]) begin
      BINARY_SCORE = vecs[i].score;
      wait_valid(lat, bcyc);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd34);
      chk($sformatf("v%0d_busy", i), 64'(bcyc), 64'd33);
      chk($sformatf("v%0d_bcd", i),
          64'(BCD_OUT), 64'(vecs[i].bcd));
      chk($sformatf("v%0d_blank", i),
          64'(BLANK), 64'(vecs[i].blank));
      chk($sformatf("v%0d_ovf", i),
          64'(OVERFLOW), 64'(vecs[i].ovf));
      @(negedge CLK);
      chk($sformatf("v%0d_vpulse", i), 64'(VALID), 64'h0);
      idle(3);
    end

    // Score changes mid-SHIFT: converted right after.
    v0 = vcnt;
    BINARY_SCORE = 32'd5;
    idle(11);
    BINARY_SCORE = 32'd77;
    wait_valid(lat, bcyc);
    chk("mid_lat1", 64'(lat), 64'd23);
    chk("mid_bcd1", 64'(BCD_OUT), 64'h5);
    chk("mid_blank1", 64'(BLANK), 64'hFE);
    wait_valid(lat, bcyc);
    chk("mid_lat2", 64'(lat), 64'd34);
    chk("mid_bcd2", 64'(BCD_OUT), 64'h77);
    chk("mid_blank2", 64'(BLANK), 64'hFC);
    idle(50);
    chk("mid_pulses", 64'(vcnt - v0), 64'd2);

    // FORCE_START with unchanged score.
    BINARY_SCORE = 32'd42;
    wait_valid(lat, bcyc);
    idle(3);
    v0 = vcnt;
    FORCE_START = 1'b1;
    @(negedge CLK);
    FORCE_START = 1'b0;
    wait_valid(lat, bcyc);
    chk("force_lat", 64'(lat), 64'd33);
    chk("force_bcd", 64'(BCD_OUT), 64'h42);
    idle(50);
    chk("force_pulses", 64'(vcnt - v0), 64'd1);

    // FORCE_START together with a change: one run.
    v0 = vcnt;
    FORCE_START  = 1'b1;
    BINARY_SCORE = 32'd43;
    @(negedge CLK);
    FORCE_START = 1'b0;
    wait_valid(lat, bcyc);
    chk("both_bcd", 64'(BCD_OUT), 64'h43);
    idle(50);
    chk("both_pulses", 64'(vcnt - v0), 64'd1);

    // Reset during SHIFT aborts; value reconverts.
    v0 = vcnt;
    BINARY_SCORE = 32'd65535;
    idle(15);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_bcd", 64'(BCD_OUT), 64'h0);
    chk("rst_blank", 64'(BLANK), 64'hFE);
    chk("rst_valid", 64'(VALID), 64'h0);
    chk("rst_busy", 64'(BUSY), 64'h0);
    chk("rst_ovf", 64'(OVERFLOW), 64'h0);
    chk("rst_nopulse", 64'(vcnt - v0), 64'h0);
    RST = 1'b0;
    wait_valid(lat, bcyc);
    chk("rst_lat", 64'(lat), 64'd34);
    chk("rst_bcd2", 64'(BCD_OUT), 64'h00065535);
    chk("rst_blank2", 64'(BLANK), 64'hE0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
